// File: rtl/regfile.sv
// General-purpose register file: two combinational read ports, one write port, x0 reads as zero.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data to matching read ports.
module regfile #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reg_write_en,
  input  logic [ADDR_WIDTH-1:0] source1_reg,
  input  logic [ADDR_WIDTH-1:0] source2_reg,
  input  logic [ADDR_WIDTH-1:0] destination_reg,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2
);

  localparam logic [ADDR_WIDTH:0] NUM_REGS_W = (ADDR_WIDTH + 1)'(NUM_REGS);

  // Register 0 has no storage; it is decoded as a constant zero on reads.
  logic [DATA_WIDTH-1:0] regs [1:NUM_REGS-1];
  logic                  wr_valid;

  assign wr_valid = reg_write_en
                    && (destination_reg != '0)
                    && ({1'b0, destination_reg} < NUM_REGS_W);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_valid) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (destination_reg == ADDR_WIDTH'(i)) begin
          regs[i] <= write_data;
        end
      end
    end
  end

  function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] addr);
    logic [DATA_WIDTH-1:0] val;
    val = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (addr == ADDR_WIDTH'(i)) begin
        val = regs[i];
      end
    end
`ifdef REGFILE_BYPASS_EN
    // wr_valid already excludes x0 and unimplemented addresses.
    if (wr_valid && !reset && (destination_reg == addr)) begin
      val = write_data;
    end
`endif
    return val;
  endfunction

  always_comb begin
    read_data1 = read_port(source1_reg);
    read_data2 = read_port(source2_reg);
  end

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile (NUM_REGS=16) against an array-based reference model.
module tb_regfile;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 16;

  logic          clk;
  logic          reset;
  logic          reg_write_en;
  logic [AW-1:0] source1_reg;
  logic [AW-1:0] source2_reg;
  logic [AW-1:0] destination_reg;
  logic [DW-1:0] write_data;
  logic [DW-1:0] read_data1;
  logic [DW-1:0] read_data2;

  int checks;
  int errors;
  logic [DW-1:0] model [NR];

  regfile #(AW, DW, NR) dut (
    .clk             (clk),
    .reset           (reset),
    .reg_write_en    (reg_write_en),
    .source1_reg     (source1_reg),
    .source2_reg     (source2_reg),
    .destination_reg (destination_reg),
    .write_data      (write_data),
    .read_data1      (read_data1),
    .read_data2      (read_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a);
    if (a == 0 || int'(a) >= NR) return '0;
`ifdef REGFILE_BYPASS_EN
    if (reg_write_en && !reset && destination_reg == a) return write_data;
`endif
    return model[a];
  endfunction

  task automatic check_reads(input string tag);
    logic [DW-1:0] e1, e2;
    e1 = exp_read(source1_reg);
    e2 = exp_read(source2_reg);
    checks++;
    assert (read_data1 === e1) else begin
      errors++;
      $error("FAIL %s rd1 addr=%0d observed=%h expected=%h", tag, source1_reg, read_data1, e1);
    end
    checks++;
    assert (read_data2 === e2) else begin
      errors++;
      $error("FAIL %s rd2 addr=%0d observed=%h expected=%h", tag, source2_reg, read_data2, e2);
    end
  endtask

  // One clock cycle: drive inputs, optionally check before the edge, advance model, check after.
  task automatic op(input logic rst, input logic we, input logic [AW-1:0] d,
                    input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                    input logic [DW-1:0] wd, input bit chk_pre, input string tag);
    @(negedge clk);
    reset = rst;
    reg_write_en = we;
    destination_reg = d;
    source1_reg = s1;
    source2_reg = s2;
    write_data = wd;
    #1;
    if (chk_pre) check_reads({tag, "_pre"});
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < NR; i++) model[i] = '0;
    end else if (we && d != 0 && int'(d) < NR) begin
      model[d] = wd;
    end
    #1;
    check_reads({tag, "_post"});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < NR; i++) model[i] = '0;
    reset = 1'b1;
    reg_write_en = 1'b0;
    destination_reg = '0;
    source1_reg = '0;
    source2_reg = '0;
    write_data = '0;

    op(1, 0, 0, 1, 15, 0, 0, "reset");
    for (int a = 0; a < 32; a += 3) op(0, 0, 0, AW'(a), AW'(31 - a), 0, 1, "reset_clear");

    op(0, 1, 1, 1, 1, 32'd100, 1, "wr1");
    op(0, 0, 0, 1, 1, 0, 1, "rd1");

    op(0, 1, 0, 0, 0, 32'hDEADBEEF, 1, "x0_wr");
    op(0, 0, 0, 0, 0, 0, 1, "x0_rd");

    op(0, 1, 3, 3, 1, 32'd7, 1, "wr3");
    for (int k = 0; k < 3; k++) op(0, 0, 3, 3, 3, 32'd55, 1, "we_gate");

    for (int r = 1; r < NR; r++) op(0, 1, AW'(r), AW'(r), 0, DW'(r), 1, "fill_idx");
    op(1, 1, 2, 2, 15, 32'd9, 1, "rst_prio");
    for (int r = 0; r < NR; r++) op(0, 0, 0, AW'(r), 2, 0, 1, "rst_all0");

    for (int r = 1; r < NR; r++) op(0, 1, AW'(r), 0, 0, DW'(r * 3 + 1), 0, "fill_oor");
    op(0, 1, 20, 20, 20, 32'h1234, 1, "oor_wr");
    for (int r = 1; r < NR; r++) op(0, 0, 0, AW'(r), 20, 0, 1, "oor_keep");

    for (int r = 1; r < NR; r++) op(0, 1, AW'(r), 0, 0, 32'd5, 0, "preset5");
    op(0, 1, 4, 4, 9, 32'd77, 1, "same_addr");
    op(0, 0, 0, 4, 4, 0, 1, "same_addr_after");

    for (int n = 0; n < 300; n++) begin
      logic rst_r, we_r;
      rst_r = ($urandom_range(0, 29) == 0);
      we_r  = ($urandom_range(0, 3) != 0);
      op(rst_r, we_r, AW'($urandom_range(0, 31)),
         AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)),
         $urandom, 1, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
